// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/flag controller for a dual-port buffer with 1-cycle registered read.
//
// Turns producer push and consumer pop requests into write/read enables and addresses for
// the buffer. Tracks occupancy, full/empty and programmable almost-full/almost-empty flags.
// A refused push (while full) or a pop while empty is latched as overflow/underflow and parks
// the controller in an error state until err_clr.
//
// Ports:
//   clk, reset_L        clock (posedge), asynchronous active-low reset
//   push, pop           producer write request / consumer read request
//   umbral_alto         almost-full threshold in entries (almost_full = count >= umbral_alto)
//   umbral_bajo         almost-empty threshold in entries (almost_empty = count <= umbral_bajo)
//   err_clr             clears the error state and its sticky flags at the next edge
//   write, read         buffer enables, combinational so the buffer acts on the same edge
//   addressW, addressR  buffer write/read pointers
//   valid_out           buffer data_out holds a popped word this cycle
//   count               occupancy, 0..MEM_LENGTH
//   full, empty         count == MEM_LENGTH / count == 0
//   almost_full/empty   threshold flags, combinational from the registered count
//   overflow, underflow sticky error causes
//   error               controller is in the error state
module fifo_ctrl #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned MEM_LENGTH = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ADDR_WIDTH:0]   umbral_alto,
  input  logic [ADDR_WIDTH:0]   umbral_bajo,
  input  logic                  err_clr,
  output logic                  write,
  output logic                  read,
  output logic [ADDR_WIDTH-1:0] addressW,
  output logic [ADDR_WIDTH-1:0] addressR,
  output logic                  valid_out,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  error
);

  localparam int unsigned CntW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0]   CountFull = CntW'(MEM_LENGTH);
  localparam logic [ADDR_WIDTH-1:0] PtrLast   = ADDR_WIDTH'(MEM_LENGTH - 1);

  typedef enum logic [1:0] {
    StVacio,
    StActivo,
    StLleno,
    StError
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  valid_q;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic accept_w, accept_r;
  logic ovf_req, unf_req;

  function automatic state_e decode_count(input logic [ADDR_WIDTH:0] c);
    if (c == '0) begin
      return StVacio;
    end else if (c == CountFull) begin
      return StLleno;
    end else begin
      return StActivo;
    end
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == PtrLast) ? '0 : p + 1'b1;
  endfunction

  // Which requests the current state is willing to take.
  always_comb begin
    accept_w = 1'b0;
    accept_r = 1'b0;
    unique case (state_q)
      StVacio: begin
        accept_w = 1'b1;
      end
      StActivo: begin
        accept_w = 1'b1;
        accept_r = 1'b1;
      end
      StLleno: begin
        // A push while full only fits if a pop frees the slot on the same edge.
        accept_w = pop;
        accept_r = 1'b1;
      end
      StError: begin
        accept_w = 1'b0;
        accept_r = 1'b0;
      end
      default: begin
        accept_w = 1'b0;
        accept_r = 1'b0;
      end
    endcase
  end

  // Gated by reset so the buffer never sees an enable while the controller is held in reset.
  assign write = reset_L & push & accept_w;
  assign read  = reset_L & pop & accept_r;

  assign ovf_req = push & ~accept_w & (state_q != StError);
  assign unf_req = pop & (state_q == StVacio);

  always_comb begin
    count_d = count_q + CntW'(write) - CntW'(read);
    wptr_d  = write ? ptr_inc(wptr_q) : wptr_q;
    rptr_d  = read  ? ptr_inc(rptr_q) : rptr_q;
    state_d = state_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (state_q == StError) begin
      if (err_clr) begin
        state_d = decode_count(count_q);
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
      end
    end else if (ovf_req || unf_req) begin
      // Error entry wins over the count decode; an accompanying push into an empty buffer
      // has still been accepted and is reflected in count_d.
      state_d = StError;
      ovf_d   = ovf_q | ovf_req;
      unf_d   = unf_q | unf_req;
    end else begin
      state_d = decode_count(count_d);
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= StVacio;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      // Buffer read data appears one cycle after the read enable.
      valid_q <= read;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign addressW     = wptr_q;
  assign addressR     = rptr_q;
  assign valid_out    = valid_q;
  assign count        = count_q;
  assign full         = (count_q == CountFull);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= umbral_alto);
  assign almost_empty = (count_q <= umbral_bajo);
  assign overflow     = ovf_q;
  assign underflow    = unf_q;
  assign error        = (state_q == StError);

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl with a behavioural buffer (1-cycle registered read).
module tb_fifo_ctrl;

  localparam int AW = 3;
  localparam int ML = 8;

  logic          clk = 1'b0;
  logic          reset_L;
  logic          push, pop, err_clr;
  logic [AW:0]   umbral_alto, umbral_bajo;
  logic          write, read, valid_out;
  logic [AW-1:0] addressW, addressR;
  logic [AW:0]   count;
  logic          full, empty, almost_full, almost_empty, overflow, underflow, error;

  always #5 clk = ~clk;

  fifo_ctrl #(
    .ADDR_WIDTH(AW),
    .MEM_LENGTH(ML)
  ) dut (
    .clk         (clk),
    .reset_L     (reset_L),
    .push        (push),
    .pop         (pop),
    .umbral_alto (umbral_alto),
    .umbral_bajo (umbral_bajo),
    .err_clr     (err_clr),
    .write       (write),
    .read        (read),
    .addressW    (addressW),
    .addressR    (addressR),
    .valid_out   (valid_out),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .overflow    (overflow),
    .underflow   (underflow),
    .error       (error)
  );

  // Behavioural dual-port buffer driven by the controller.
  logic [7:0] mem [ML];
  logic [7:0] wdata;
  logic [7:0] data_out;

  always @(posedge clk) begin
    if (write) mem[addressW] <= wdata;
    if (read)  data_out <= mem[addressR];
  end

  int n_vec = 0;
  int n_err = 0;

  // Reference model of the controller as seen at its ports.
  int         mcount, mwp, mrp;
  bit         merr, movf, munf, last_r;
  logic [7:0] mq[$];
  logic [7:0] sb[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mcount = 0;
    mwp    = 0;
    mrp    = 0;
    merr   = 1'b0;
    movf   = 1'b0;
    munf   = 1'b0;
    last_r = 1'b0;
    mq.delete();
    sb.delete();
  endtask

  task automatic check_state();
    check_eq("count", 32'(count), mcount);
    check_eq("full", 32'(full), 32'(mcount == ML));
    check_eq("empty", 32'(empty), 32'(mcount == 0));
    check_eq("almost_full", 32'(almost_full), 32'(mcount >= int'(umbral_alto)));
    check_eq("almost_empty", 32'(almost_empty), 32'(mcount <= int'(umbral_bajo)));
    check_eq("error", 32'(error), 32'(merr));
    check_eq("overflow", 32'(overflow), 32'(movf));
    check_eq("underflow", 32'(underflow), 32'(munf));
    check_eq("addressW", 32'(addressW), mwp);
    check_eq("addressR", 32'(addressR), mrp);
    check_eq("valid_out", 32'(valid_out), 32'(last_r));
    if (last_r && sb.size() > 0) check_eq("data_out", 32'(data_out), 32'(sb.pop_front()));
  endtask

  // One clock cycle: drive at negedge, check enables, then check state at the next negedge.
  task automatic cycle(input bit p, input bit q, input logic [7:0] d);
    bit ew, er;
    push  = p;
    pop   = q;
    wdata = d;
    #1;
    ew = p && !merr && (mcount < ML || q);
    er = q && !merr && (mcount > 0);
    check_eq("write", 32'(write), 32'(ew));
    check_eq("read", 32'(read), 32'(er));
    if (ew) mq.push_back(d);
    if (er && mq.size() > 0) sb.push_back(mq.pop_front());
    if (!merr && p && !ew) begin
      merr = 1'b1;
      movf = 1'b1;
    end
    if (!merr && q && mcount == 0) begin
      merr = 1'b1;
      munf = 1'b1;
    end
    if (merr && q && mcount == 0 && !movf) munf = 1'b1;
    mcount = mcount + int'(ew) - int'(er);
    if (ew) mwp = (mwp + 1) % ML;
    if (er) mrp = (mrp + 1) % ML;
    last_r = er;
    @(negedge clk);
    push = 1'b0;
    pop  = 1'b0;
    check_state();
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    push    = 1'b0;
    pop     = 1'b0;
    @(negedge clk);
    err_clr = 1'b0;
    merr    = 1'b0;
    movf    = 1'b0;
    munf    = 1'b0;
    last_r  = 1'b0;
    check_state();
  endtask

  // Assert reset at a negedge with the given requests held, check immediately, hold, release.
  task automatic do_reset(input bit p, input bit q, input int cycles);
    reset_L = 1'b0;
    push    = p;
    pop     = q;
    model_reset();
    #1;
    check_eq("rst_write", 32'(write), 0);
    check_eq("rst_read", 32'(read), 0);
    check_state();
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check_eq("rst_write", 32'(write), 0);
      check_eq("rst_read", 32'(read), 0);
      check_state();
    end
    reset_L = 1'b1;
    push    = 1'b0;
    pop     = 1'b0;
  endtask

  initial begin
    reset_L     = 1'b0;
    push        = 1'b1;
    pop         = 1'b1;
    err_clr     = 1'b0;
    wdata       = '0;
    umbral_alto = 4'd6;
    umbral_bajo = 4'd2;
    model_reset();
    @(negedge clk);

    // Reset held with both requests asserted.
    do_reset(1'b1, 1'b1, 3);

    // Fill and drain, then a partial round so the next fill wraps mid-buffer.
    for (int i = 1; i <= ML; i++) cycle(1'b1, 1'b0, 8'(i));
    for (int i = 0; i < ML; i++) cycle(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'(16 + i));
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'h00);
    for (int i = 1; i <= ML; i++) cycle(1'b1, 1'b0, 8'(32 + i));
    for (int i = 0; i < ML; i++) cycle(1'b0, 1'b1, 8'h00);

    // Full with simultaneous push and pop: count holds, oldest words come out.
    for (int i = 1; i <= ML; i++) cycle(1'b1, 1'b0, 8'(48 + i));
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 8'(64 + i));

    // Overflow: requests ignored until err_clr, then back to full.
    cycle(1'b1, 1'b0, 8'hAA);
    cycle(1'b1, 1'b1, 8'hAB);
    cycle(1'b0, 1'b1, 8'h00);
    clear_err();
    for (int i = 0; i < ML; i++) cycle(1'b0, 1'b1, 8'h00);

    // Underflow with a simultaneous push that is still accepted.
    cycle(1'b1, 1'b1, 8'h5A);
    cycle(1'b0, 1'b1, 8'h00);
    clear_err();
    cycle(1'b0, 1'b1, 8'h00);

    // Thresholds, then reset in the middle of a push burst.
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 8'(80 + i));
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'(96 + i));
    do_reset(1'b1, 1'b0, 1);

    // Threshold extremes: both almost flags stay high across the whole range.
    umbral_alto = 4'd0;
    umbral_bajo = 4'd8;
    #1;
    check_state();
    for (int i = 0; i < ML; i++) cycle(1'b1, 1'b0, 8'(112 + i));
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
